fsmc_nand_sync: RTL and testbench

FSMC_NAND_SYNC -- requirements
Module: fsmc_nand_sync

---
 rtl/fsmc_nand_sync_if.sv | 31 +++
 rtl/fsmc_nand_sync.sv | 173 +++++++++++++++++
 tb/tb_fsmc_nand_sync.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fsmc_nand_sync_if.sv
// fsmc_nand_sync_if: FSMC NAND pin bundle plus page-memory port
interface fsmc_nand_sync_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  CLE;
  logic                  ALE;
  logic                  NCE;
  logic                  NWE;
  logic                  NRE;
  logic [DATA_WIDTH-1:0] DQ_IN;
  logic [DATA_WIDTH-1:0] DQ_OUT;
  logic                  DQ_OE;
  logic                  NWAIT;
  logic                  RESET_FSMC;
  logic [15:0]           COLUMN_ADDR;
  logic [15:0]           ROW_ADDR;
  logic                  MEM_WR_EN;
  logic [DATA_WIDTH-1:0] MEM_WR_DATA;
  logic                  MEM_RD_EN;
  logic [DATA_WIDTH-1:0] MEM_RD_DATA;
  modport slave (
    input  CLE, ALE, NCE, NWE, NRE, DQ_IN, MEM_RD_DATA,
    output DQ_OUT, DQ_OE, NWAIT, RESET_FSMC, COLUMN_ADDR, ROW_ADDR,
           MEM_WR_EN, MEM_WR_DATA, MEM_RD_EN
  );
  modport master (
    output CLE, ALE, NCE, NWE, NRE, DQ_IN, MEM_RD_DATA,
    input  DQ_OUT, DQ_OE, NWAIT, RESET_FSMC, COLUMN_ADDR, ROW_ADDR,
           MEM_WR_EN, MEM_WR_DATA, MEM_RD_EN
  );
endinterface

// File: rtl/fsmc_nand_sync.sv
// fsmc_nand_sync: NAND-flash target emulation for an FSMC host, bridging async strobes to a synchronous page memory
module fsmc_nand_sync #(
  parameter int          DATA_WIDTH  = 16,
  parameter int          COL_CYCLES  = 2,
  parameter int          ROW_CYCLES  = 2,
  parameter int          PAGE_WORDS  = 2048,
  parameter int          PROG_CYCLES = 64,
  parameter logic [31:0] ID_WORD     = 32'hEC_D3_51_95
) (
  input logic             CLK,
  input logic             NRST,
  fsmc_nand_sync_if.slave bus
);
  localparam int PCW = $clog2(PROG_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, PROG, STATUS, ID} state_e;
  state_e                state_q, state_d;
  logic [1:0]            rst_sync_q;
  logic                  rst_n;
  logic [1:0]            cle_q, ale_q, nce_q, nwe_q, nre_q;
  logic [DATA_WIDTH-1:0] dq1_q, dq2_q;
  logic                  nwe_p_q, nre_p_q;
  logic [15:0]           col_q, col_d, row_q, row_d;
  logic [1:0]            ac_q, ac_d, id_q, id_d;
  logic                  wr_q, wr_d, ready_q, ready_d;
  logic [PCW-1:0]        prog_q, prog_d;
  logic [DATA_WIDTH-1:0] dq_q, dq_d, wdat_q, wdat_d;
  logic                  wen_q, wen_d, ren_q, ren_d, rpend_q, rstp_q, rstp_d;
  logic                  cle_s, ale_s, nce_s, nwe_rise, nre_rise;
  logic                  cmd, adr, dat, rde, is_col, hi;
  logic [7:0]            c;
  logic [15:0]           col_inc;
  // Reset asserts at once and is released only after two clean clock edges
  always_ff @(posedge CLK or negedge NRST)
    if (!NRST) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  // Two-stage synchronisers for strobes and data, plus one stage of history for edge detection
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      {cle_q, ale_q} <= '0;
      {nce_q, nwe_q, nre_q} <= '1;
      {nwe_p_q, nre_p_q} <= '1;
      {dq1_q, dq2_q} <= '0;
    end else begin
      cle_q <= {cle_q[0], bus.CLE};
      ale_q <= {ale_q[0], bus.ALE};
      nce_q <= {nce_q[0], bus.NCE};
      nwe_q <= {nwe_q[0], bus.NWE};
      nre_q <= {nre_q[0], bus.NRE};
      dq1_q <= bus.DQ_IN;
      dq2_q <= dq1_q;
      nwe_p_q <= nwe_q[1];
      nre_p_q <= nre_q[1];
    end
  assign cle_s    = cle_q[1];
  assign ale_s    = ale_q[1];
  assign nce_s    = nce_q[1];
  assign nwe_rise = nwe_q[1] & ~nwe_p_q;
  assign nre_rise = nre_q[1] & ~nre_p_q;
  assign cmd      = nwe_rise & cle_s & ~ale_s & ~nce_s;
  assign adr      = nwe_rise & ale_s & ~cle_s & ~nce_s;
  assign dat      = nwe_rise & ~cle_s & ~ale_s & ~nce_s;
  assign rde      = nre_rise & ~nwe_rise & ~nce_s;
  assign c        = dq2_q[7:0];
  assign col_inc  = (col_q == 16'(PAGE_WORDS - 1)) ? '0 : col_q + 16'd1;
  assign is_col   = ac_q < 2'(COL_CYCLES);
  assign hi       = ac_q[0] ^ (!is_col && COL_CYCLES == 1);
  // Controller state, address and datapath registers
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      {col_q, row_q, ac_q, id_q, wr_q, prog_q} <= '0;
      ready_q <= 1'b1;
      {dq_q, wdat_q, wen_q, ren_q, rpend_q, rstp_q} <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ac_q    <= ac_d;
      id_q    <= id_d;
      wr_q    <= wr_d;
      prog_q  <= prog_d;
      ready_q <= ready_d;
      dq_q    <= dq_d;
      wdat_q  <= wdat_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      rpend_q <= ren_q;
      rstp_q  <= rstp_d;
    end
  // Next state: per-state actions first, then command decode, then chip-enable abort
  always_comb begin
    state_d = state_q;
    col_d   = wen_q ? col_inc : col_q;
    row_d   = row_q;
    ac_d    = ac_q;
    id_d    = id_q;
    wr_d    = wr_q;
    prog_d  = prog_q;
    ready_d = ready_q;
    dq_d    = rpend_q ? bus.MEM_RD_DATA : dq_q;
    wdat_d  = wdat_q;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    rstp_d  = 1'b0;
    case (state_q)
      ADDR: if (adr) begin
        if (is_col) col_d = hi ? {c, col_q[7:0]} : {col_q[15:8], c};
        else row_d = hi ? {c, row_q[7:0]} : {row_q[15:8], c};
        ac_d = ac_q + 2'd1;
        if (ac_q == 2'(COL_CYCLES + ROW_CYCLES - 1)) state_d = wr_q ? WDATA : IDLE;
      end
      WDATA: if (dat) begin
        wen_d  = 1'b1;
        wdat_d = dq2_q;
      end
      RDATA: if (rde) begin
        col_d = col_inc;
        ren_d = 1'b1;
      end
      PROG: begin
        prog_d = prog_q - PCW'(1);
        if (prog_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      ID: if (rde) id_d = id_q + 2'd1;
      default: ;
    endcase
    if (cmd && (state_q != PROG || c == 8'hFF))
      case (c)
        8'h00, 8'h80: begin
          state_d = ADDR;
          col_d   = '0;
          row_d   = '0;
          ac_d    = '0;
          wr_d    = c[7];
        end
        8'h30: begin
          state_d = RDATA;
          ren_d   = 1'b1;
        end
        8'h10: begin
          state_d = PROG;
          ready_d = 1'b0;
          prog_d  = PCW'(PROG_CYCLES - 1);
        end
        8'hFF: begin
          state_d = IDLE;
          ready_d = 1'b1;
          rstp_d  = 1'b1;
        end
        8'h70: state_d = STATUS;
        8'h90: begin
          state_d = ID;
          id_d    = '0;
        end
        default: ;
      endcase
    if (nce_s && state_q != PROG) state_d = IDLE;
  end
  assign bus.DQ_OUT      = (state_q == STATUS || state_q == PROG) ? DATA_WIDTH'({1'b1, ready_q, 6'b0}) :
                           (state_q == ID) ? DATA_WIDTH'(ID_WORD[{id_q, 3'b0} +: 8]) : dq_q;
  assign bus.DQ_OE       = ~nce_s & ~nre_q[1];
  assign bus.NWAIT       = ~(ren_q | rpend_q);
  assign bus.RESET_FSMC  = rstp_q;
  assign bus.COLUMN_ADDR = col_q;
  assign bus.ROW_ADDR    = row_q;
  assign bus.MEM_WR_EN   = wen_q;
  assign bus.MEM_WR_DATA = wdat_q;
  assign bus.MEM_RD_EN   = ren_q;
endmodule

// File: tb/tb_fsmc_nand_sync.sv
// tb_fsmc_nand_sync: table-driven host transactions with write/read scoreboards
module tb_fsmc_nand_sync;
  typedef enum logic [3:0] {OP_CMD, OP_ADR, OP_DAT, OP_RD, OP_RS, OP_PRG, OP_NCEH, OP_DNW, OP_ARST} op_e;
  typedef struct {
    op_e         op;
    logic [15:0] val;
    logic [15:0] exp;
  } vec_t;
  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic [15:0] mem_rd = '0;
  int          n_cmp = 0, n_bad = 0, wr_cnt = 0, rst_cnt = 0;
  logic [15:0] m_col = '0, m_row = '0;
  int          m_ac = 0;
  logic [47:0] wr_q[$];
  logic [15:0] rd_q[$];
  logic [47:0] we;
  logic [15:0] re;
  vec_t        tbl[$];
  fsmc_nand_sync_if #(.DATA_WIDTH(16)) b();
  fsmc_nand_sync dut (.CLK(CLK), .NRST(NRST), .bus(b));
  always #5 CLK = ~CLK;
  // page memory: registered read, one cycle after MEM_RD_EN
  assign b.MEM_RD_DATA = mem_rd;
  always @(posedge CLK) if (b.MEM_RD_EN) mem_rd <= {4'h9, b.COLUMN_ADDR[11:0]};
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [15:0] inc(input logic [15:0] x);
    return (x == 16'd2047) ? 16'd0 : x + 16'd1;
  endfunction
  function automatic void add(input op_e o, input logic [15:0] v, input logic [15:0] e);
    tbl.push_back('{op: o, val: v, exp: e});
  endfunction
  task automatic host_wr(input logic cl, input logic al, input logic [15:0] v, output int lo);
    @(posedge CLK);
    #1 b.CLE = cl; b.ALE = al; b.DQ_IN = v; b.NWE = 1'b0;
    repeat (3) @(posedge CLK);
    #1 b.NWE = 1'b1;
    lo = 0;
    repeat (8) begin
      @(negedge CLK);
      if (!b.NWAIT) lo++;
    end
    b.CLE = 1'b0;
    b.ALE = 1'b0;
  endtask
  task automatic host_rd(output logic [15:0] d, output logic oe, output int lo);
    @(posedge CLK);
    #1 b.NRE = 1'b0;
    repeat (4) @(negedge CLK);
    d  = b.DQ_OUT;
    oe = b.DQ_OE;
    @(posedge CLK);
    #1 b.NRE = 1'b1;
    lo = 0;
    repeat (8) begin
      @(negedge CLK);
      if (!b.NWAIT) lo++;
    end
  endtask
  // scoreboard: every memory strobe must match the next queued expectation
  always @(negedge CLK) begin
    if (b.MEM_WR_EN) begin
      wr_cnt++;
      check("wr_expected", 32'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) begin
        we = wr_q.pop_front();
        check("wr_col", b.COLUMN_ADDR, we[47:32]);
        check("wr_row", b.ROW_ADDR, we[31:16]);
        check("wr_data", b.MEM_WR_DATA, we[15:0]);
      end
    end
    if (b.MEM_RD_EN) begin
      check("rd_expected", 32'(rd_q.size() != 0), 1);
      if (rd_q.size() != 0) begin
        re = rd_q.pop_front();
        check("rd_col", b.COLUMN_ADDR, re);
      end
    end
    if (b.RESET_FSMC) rst_cnt++;
  end
  initial begin
    vec_t        t;
    logic [15:0] d;
    logic        oe;
    int          lo, w0, r0, busy;
    b.CLE = 1'b0; b.ALE = 1'b0; b.NCE = 1'b0; b.NWE = 1'b1; b.NRE = 1'b1; b.DQ_IN = '0;
    add(OP_CMD, 16'h70, 0); add(OP_RS, 0, 16'h00C0);
    add(OP_CMD, 16'h80, 0); add(OP_ADR, 16'h04, 0); add(OP_ADR, 16'h00, 0); add(OP_ADR, 16'h07, 0); add(OP_ADR, 16'h00, 0);
    add(OP_DAT, 16'hAAAA, 0); add(OP_DAT, 16'hBBBB, 0); add(OP_DAT, 16'hCCCC, 0);
    add(OP_PRG, 0, 0); add(OP_CMD, 16'h70, 0); add(OP_RS, 0, 16'h00C0);
    add(OP_CMD, 16'h00, 0); add(OP_ADR, 16'hFE, 0); add(OP_ADR, 16'h07, 0); add(OP_ADR, 16'h00, 0); add(OP_ADR, 16'h00, 0);
    add(OP_CMD, 16'h30, 0); add(OP_RD, 0, 16'h97FE); add(OP_RD, 0, 16'h97FF); add(OP_RD, 0, 16'h9000);
    add(OP_CMD, 16'h90, 0); add(OP_RS, 0, 16'h0095); add(OP_RS, 0, 16'h0051); add(OP_RS, 0, 16'h00D3);
    add(OP_RS, 0, 16'h00EC); add(OP_RS, 0, 16'h0095);
    add(OP_CMD, 16'h80, 0); add(OP_ADR, 16'h00, 0); add(OP_ADR, 16'h00, 0); add(OP_ADR, 16'h01, 0); add(OP_ADR, 16'h00, 0);
    add(OP_DAT, 16'h1111, 0); add(OP_NCEH, 0, 0); add(OP_DNW, 16'h2222, 0); add(OP_CMD, 16'hFF, 0);
    add(OP_CMD, 16'h10, 0); add(OP_CMD, 16'hFF, 0); add(OP_CMD, 16'h70, 0); add(OP_RS, 0, 16'h00C0);
    add(OP_CMD, 16'h00, 0); add(OP_ADR, 16'h23, 0); add(OP_ADR, 16'h01, 0); add(OP_ADR, 16'h00, 0); add(OP_ADR, 16'h00, 0);
    add(OP_CMD, 16'h30, 0); add(OP_ARST, 0, 16'h9123);
    repeat (3) @(posedge CLK);
    #1 NRST = 1'b1;
    repeat (4) @(negedge CLK);
    check("rst_dq_out", b.DQ_OUT, 0);
    check("rst_dq_oe", b.DQ_OE, 0);
    check("rst_nwait", b.NWAIT, 1);
    check("rst_reset_fsmc", b.RESET_FSMC, 0);
    check("rst_col", b.COLUMN_ADDR, 0);
    check("rst_row", b.ROW_ADDR, 0);
    check("rst_wr_en", b.MEM_WR_EN, 0);
    check("rst_rd_en", b.MEM_RD_EN, 0);
    foreach (tbl[i]) begin
      t = tbl[i];
      case (t.op)
        OP_CMD: begin
          r0 = rst_cnt;
          if (t.val == 16'h00 || t.val == 16'h80) begin
            m_col = '0;
            m_row = '0;
            m_ac  = 0;
          end
          if (t.val == 16'h30) rd_q.push_back(m_col);
          host_wr(1'b1, 1'b0, t.val, lo);
          check($sformatf("cmd%02h_nwait_low", t.val[7:0]), lo, (t.val == 16'h30) ? 2 : 0);
          check($sformatf("cmd%02h_reset_pulse", t.val[7:0]), rst_cnt - r0, (t.val == 16'hFF) ? 1 : 0);
        end
        OP_ADR: begin
          if (m_ac < 2) m_col[8*m_ac +: 8] = t.val[7:0];
          else m_row[8*(m_ac-2) +: 8] = t.val[7:0];
          m_ac++;
          host_wr(1'b0, 1'b1, t.val, lo);
        end
        OP_DAT: begin
          wr_q.push_back({m_col, m_row, t.val});
          m_col = inc(m_col);
          host_wr(1'b0, 1'b0, t.val, lo);
        end
        OP_DNW: begin
          w0 = wr_cnt;
          host_wr(1'b0, 1'b0, t.val, lo);
          repeat (4) @(negedge CLK);
          check("abort_no_write", wr_cnt - w0, 0);
        end
        OP_RD: begin
          m_col = inc(m_col);
          rd_q.push_back(m_col);
          host_rd(d, oe, lo);
          check("rd_data", d, t.exp);
          check("rd_oe", oe, 1);
          check("rd_refill_nwait_low", lo, 2);
        end
        OP_RS: begin
          host_rd(d, oe, lo);
          check("rs_data", d, t.exp);
          check("rs_oe", oe, 1);
        end
        OP_NCEH: begin
          @(posedge CLK);
          #1 b.NCE = 1'b1;
          repeat (6) @(posedge CLK);
          #1 b.NCE = 1'b0;
          repeat (4) @(posedge CLK);
        end
        OP_PRG: begin
          busy = 0;
          @(posedge CLK);
          #1 b.CLE = 1'b1; b.DQ_IN = 16'h0010; b.NWE = 1'b0;
          repeat (3) @(posedge CLK);
          #1 b.NWE = 1'b1;
          for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (b.DQ_OUT == 16'h0080) busy++;
            if (k == 20) b.NCE = 1'b1;
            if (k == 30) b.NCE = 1'b0;
          end
          b.CLE = 1'b0;
          check("prog_busy_cycles", busy, 64);
        end
        OP_ARST: begin
          @(posedge CLK);
          #1 b.NRE = 1'b0;
          repeat (4) @(negedge CLK);
          check("pre_rst_dq_out", b.DQ_OUT, t.exp);
          check("pre_rst_dq_oe", b.DQ_OE, 1);
          @(posedge CLK);
          #2 NRST = 1'b0;
          #1;
          check("arst_dq_out", b.DQ_OUT, 0);
          check("arst_dq_oe", b.DQ_OE, 0);
          check("arst_nwait", b.NWAIT, 1);
          check("arst_reset_fsmc", b.RESET_FSMC, 0);
          check("arst_col", b.COLUMN_ADDR, 0);
          check("arst_row", b.ROW_ADDR, 0);
          check("arst_wr_en", b.MEM_WR_EN, 0);
          check("arst_rd_en", b.MEM_RD_EN, 0);
          repeat (3) @(posedge CLK);
          #1 NRST = 1'b1; b.NRE = 1'b1;
          repeat (5) @(posedge CLK);
        end
        default: ;
      endcase
    end
    repeat (4) @(negedge CLK);
    check("wr_queue_drained", wr_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
